// File: rtl/exmem_cc_stage.sv
// Execute-stage back end for the Y86-64 pipeline. It holds the condition-code register and the
// E->M pipeline register.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   e_*                      instruction currently in E (icode/ifun/stat/valE/valA/dstE/dstM)
//   alu_zf/sf/of             flags produced by the ALU for the op in E
//   m_stat, W_stat           status of the older instructions in M and W
//   M_stall, M_bubble        pipeline-control hold / nop-inject for the E->M register
//   cc_zf/sf/of              registered condition codes
//   e_cnd                    condition result for e_ifun against the stored CC (combinational)
//   e_dstE_eff               e_dstE, or REG_NONE for a cmov whose condition failed
//   M_*                      registered E->M pipeline contents
module exmem_cc_stage #(
  parameter int unsigned WIDTH     = 64,
  parameter logic [3:0]  REG_NONE  = 4'hF,
  parameter logic [3:0]  ICODE_NOP = 4'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [1:0]       e_stat,
  input  logic [WIDTH-1:0] e_valE,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             e_cnd,
  output logic [3:0]       e_dstE_eff,
  output logic [3:0]       M_icode,
  output logic [3:0]       M_ifun,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic [1:0]       M_stat,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA
);

  localparam logic [3:0] IcodeCmov = 4'h2;
  localparam logic [3:0] IcodeOpq  = 4'h6;
  localparam logic [1:0] StatAok   = 2'd0;

  logic cc_zf_q, cc_sf_q, cc_of_q;
  logic cc_we;

  logic [3:0]       m_icode_q, m_ifun_q, m_dste_q, m_dstm_q;
  logic [1:0]       m_stat_q;
  logic             m_cnd_q;
  logic [WIDTH-1:0] m_vale_q, m_vala_q;

  // An OPq writes the CC only when nothing older has faulted, so a younger OPq cannot change
  // the CC behind an exception.
  assign cc_we = (e_icode == IcodeOpq) && (e_stat == StatAok) &&
                 (m_stat == StatAok) && (W_stat == StatAok);

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_zf_q <= 1'b1;
      cc_sf_q <= 1'b0;
      cc_of_q <= 1'b0;
    end else if (cc_we) begin
      cc_zf_q <= alu_zf;
      cc_sf_q <= alu_sf;
      cc_of_q <= alu_of;
    end
  end

  always_comb begin
    e_cnd = 1'b0;
    unique case (e_ifun)
      4'd0:    e_cnd = 1'b1;
      4'd1:    e_cnd = (cc_sf_q ^ cc_of_q) | cc_zf_q;
      4'd2:    e_cnd = cc_sf_q ^ cc_of_q;
      4'd3:    e_cnd = cc_zf_q;
      4'd4:    e_cnd = ~cc_zf_q;
      4'd5:    e_cnd = ~(cc_sf_q ^ cc_of_q);
      4'd6:    e_cnd = ~(cc_sf_q ^ cc_of_q) & ~cc_zf_q;
      default: e_cnd = 1'b0;
    endcase
  end

  assign e_dstE_eff = ((e_icode == IcodeCmov) && !e_cnd) ? REG_NONE : e_dstE;

  // Priority: reset > bubble > stall > load. The bubble value equals the reset value.
  always_ff @(posedge clk) begin
    if (rst || M_bubble) begin
      m_icode_q <= ICODE_NOP;
      m_ifun_q  <= 4'h0;
      m_stat_q  <= StatAok;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= REG_NONE;
      m_dstm_q  <= REG_NONE;
    end else if (!M_stall) begin
      m_icode_q <= e_icode;
      m_ifun_q  <= e_ifun;
      m_stat_q  <= e_stat;
      m_cnd_q   <= e_cnd;
      m_vale_q  <= e_valE;
      m_vala_q  <= e_valA;
      m_dste_q  <= e_dstE_eff;
      m_dstm_q  <= e_dstM;
    end
  end

  assign cc_zf   = cc_zf_q;
  assign cc_sf   = cc_sf_q;
  assign cc_of   = cc_of_q;
  assign M_icode = m_icode_q;
  assign M_ifun  = m_ifun_q;
  assign M_dstE  = m_dste_q;
  assign M_dstM  = m_dstm_q;
  assign M_stat  = m_stat_q;
  assign M_cnd   = m_cnd_q;
  assign M_valE  = m_vale_q;
  assign M_valA  = m_vala_q;

endmodule

// File: tb/tb_exmem_cc_stage.sv
module tb_exmem_cc_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  e_icode, e_ifun, e_dstE, e_dstM;
  logic [1:0]  e_stat, m_stat, W_stat;
  logic [63:0] e_valE, e_valA;
  logic        alu_zf, alu_sf, alu_of, M_stall, M_bubble;
  logic        cc_zf, cc_sf, cc_of, e_cnd, M_cnd;
  logic [3:0]  e_dstE_eff, M_icode, M_ifun, M_dstE, M_dstM;
  logic [1:0]  M_stat;
  logic [63:0] M_valE, M_valA;

  int checks = 0;
  int failures = 0;

  // Reference state
  bit          r_zf, r_sf, r_of;
  logic [3:0]  r_icode, r_ifun, r_dste, r_dstm;
  logic [1:0]  r_stat;
  bit          r_cnd;
  logic [63:0] r_vale, r_vala;

  exmem_cc_stage dut (
    .clk(clk), .rst(rst), .e_icode(e_icode), .e_ifun(e_ifun), .e_stat(e_stat),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .e_cnd(e_cnd), .e_dstE_eff(e_dstE_eff), .M_icode(M_icode), .M_ifun(M_ifun),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Y86-64 condition semantics: "less" is sf!=of, "equal" is zf.
  function automatic bit ref_cond(input logic [3:0] ifun, input bit zf, input bit sf,
                                  input bit of);
    bit lt;
    lt = (sf != of);
    case (ifun)
      4'd0:    return 1'b1;
      4'd1:    return lt || zf;
      4'd2:    return lt;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !lt;
      4'd6:    return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Check combinational outputs, clock once, advance the model, check registered outputs.
  task automatic step();
    bit         c;
    logic [3:0] eff;
    #1;
    c   = ref_cond(e_ifun, r_zf, r_sf, r_of);
    eff = (e_icode == 4'd2 && !c) ? 4'hF : e_dstE;
    check("e_cnd", {63'd0, e_cnd}, {63'd0, c});
    check("e_dstE_eff", {60'd0, e_dstE_eff}, {60'd0, eff});
    @(posedge clk);
    if (!rst && e_icode == 4'd6 && e_stat == 0 && m_stat == 0 && W_stat == 0) begin
      r_zf = alu_zf; r_sf = alu_sf; r_of = alu_of;
    end
    if (rst) begin
      r_zf = 1'b1; r_sf = 1'b0; r_of = 1'b0;
    end
    if (rst || M_bubble) begin
      r_icode = 4'h1; r_ifun = 4'h0; r_stat = 2'd0; r_cnd = 1'b0;
      r_vale = '0; r_vala = '0; r_dste = 4'hF; r_dstm = 4'hF;
    end else if (!M_stall) begin
      r_icode = e_icode; r_ifun = e_ifun; r_stat = e_stat; r_cnd = c;
      r_vale = e_valE; r_vala = e_valA; r_dste = eff; r_dstm = e_dstM;
    end
    #1;
    check("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, r_zf, r_sf, r_of});
    check("M_icode", {60'd0, M_icode}, {60'd0, r_icode});
    check("M_ifun", {60'd0, M_ifun}, {60'd0, r_ifun});
    check("M_stat", {62'd0, M_stat}, {62'd0, r_stat});
    check("M_cnd", {63'd0, M_cnd}, {63'd0, r_cnd});
    check("M_dstE", {60'd0, M_dstE}, {60'd0, r_dste});
    check("M_dstM", {60'd0, M_dstM}, {60'd0, r_dstm});
    check("M_valE", M_valE, r_vale);
    check("M_valA", M_valA, r_vala);
  endtask

  task automatic idle_inputs();
    rst = 0; e_icode = 4'h0; e_ifun = 4'h0; e_stat = 0; m_stat = 0; W_stat = 0;
    e_valE = '0; e_valA = '0; e_dstE = 4'hF; e_dstM = 4'hF;
    alu_zf = 0; alu_sf = 0; alu_of = 0; M_stall = 0; M_bubble = 0;
  endtask

  task automatic set_cc(input bit zf, input bit sf, input bit of);
    idle_inputs();
    e_icode = 4'h6; alu_zf = zf; alu_sf = sf; alu_of = of;
    step();
  endtask

  initial begin
    idle_inputs();
    // T1: reset for two cycles
    rst = 1;
    step();
    step();
    check("T1 cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'h4);
    check("T1 M_icode", {60'd0, M_icode}, 64'h1);
    check("T1 M_dstE", {60'd0, M_dstE}, 64'hF);
    check("T1 M_dstM", {60'd0, M_dstM}, 64'hF);
    check("T1 M_valE", M_valE, 64'h0);

    // T2: OPq sets flags, visible to a jXX the next cycle
    set_cc(1'b0, 1'b1, 1'b0);
    check("T2 cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'h2);
    e_icode = 4'h7; e_ifun = 4'h2; #1;
    check("T2 jl", {63'd0, e_cnd}, 64'h1);
    e_ifun = 4'h3; #1;
    check("T2 je", {63'd0, e_cnd}, 64'h0);

    // T3: failed cmov squashes dstE, taken cmov keeps it
    idle_inputs();
    e_icode = 4'h2; e_ifun = 4'h3; e_dstE = 4'h3; #1;
    check("T3 eff", {60'd0, e_dstE_eff}, 64'hF);
    step();
    check("T3 M_dstE", {60'd0, M_dstE}, 64'hF);
    check("T3 M_cnd", {63'd0, M_cnd}, 64'h0);
    set_cc(1'b1, 1'b0, 1'b0);
    idle_inputs();
    e_icode = 4'h2; e_ifun = 4'h3; e_dstE = 4'h3;
    step();
    check("T3 taken M_dstE", {60'd0, M_dstE}, 64'h3);
    check("T3 taken M_cnd", {63'd0, M_cnd}, 64'h1);

    // T4: non-AOK in E, M or W blocks the CC write (cc is zf=1 here)
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      e_icode = 4'h6; alu_zf = 0; alu_sf = 1; alu_of = 1;
      if (k == 0) m_stat = 2'd2;
      else if (k == 1) W_stat = 2'd1;
      else e_stat = 2'd3;
      step();
      check("T4 cc held", {61'd0, cc_zf, cc_sf, cc_of}, 64'h4);
    end

    // T5: stall holds, bubble wins over stall, CC still updates
    idle_inputs();
    e_valE = 64'h1234;
    step();
    check("T5 load", M_valE, 64'h1234);
    for (int k = 0; k < 3; k++) begin
      e_valE = {$urandom, $urandom}; e_icode = 4'($urandom); M_stall = 1;
      step();
      check("T5 stall", M_valE, 64'h1234);
    end
    M_bubble = 1; e_icode = 4'h6; alu_zf = 0; alu_sf = 0; alu_of = 1;
    step();
    check("T5 bubble icode", {60'd0, M_icode}, 64'h1);
    check("T5 bubble dstE", {60'd0, M_dstE}, 64'hF);
    check("T5 bubble valE", M_valE, 64'h0);
    check("T5 cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'h1);

    // T6: condition table sweep over all CC combinations
    for (int c = 0; c < 8; c++) begin
      set_cc(c[2], c[1], c[0]);
      for (int f = 0; f < 16; f++) begin
        e_icode = 4'h7; e_ifun = 4'(f); #1;
        check("T6 cond", {63'd0, e_cnd}, {63'd0, ref_cond(4'(f), c[2], c[1], c[0])});
      end
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      e_icode  = (r < 3) ? 4'h6 : (r < 5) ? 4'h2 : (r < 6) ? 4'h7 : 4'($urandom);
      e_ifun   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom);
      e_stat   = ($urandom_range(0, 9) < 8) ? 2'd0 : 2'($urandom);
      m_stat   = ($urandom_range(0, 9) < 8) ? 2'd0 : 2'($urandom);
      W_stat   = ($urandom_range(0, 9) < 8) ? 2'd0 : 2'($urandom);
      e_valE   = {$urandom, $urandom};
      e_valA   = {$urandom, $urandom};
      e_dstE   = 4'($urandom);
      e_dstM   = 4'($urandom);
      alu_zf   = 1'($urandom); alu_sf = 1'($urandom); alu_of = 1'($urandom);
      M_stall  = ($urandom_range(0, 99) < 15);
      M_bubble = ($urandom_range(0, 99) < 10);
      rst      = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
